// File: rtl/pred_merge_queue_pkg.sv
// Shared predictor definitions: payload field layout, branch type codes and
// the output-side handshake states used by the merge queue.
package pred_merge_queue_pkg;

   localparam int ADDR_W   = 32;
   localparam int JPOS_W   = 3;
   localparam int TYPE_W   = 3;
   localparam int CUT_W    = 8;

   localparam int CUT_LSB  = 0;
   localparam int TYPE_LSB = CUT_LSB + CUT_W;
   localparam int JPOS_LSB = TYPE_LSB + TYPE_W;
   localparam int ADDR_LSB = JPOS_LSB + JPOS_W;

   localparam int PAYLOAD_W = ADDR_W + JPOS_W + TYPE_W + CUT_W;

   typedef enum logic [TYPE_W-1:0] {
      BR_NONE = 3'd0,
      BR_COND = 3'd1,
      BR_JAL  = 3'd2,
      BR_JALR = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5
   } predType_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } outState_e;

   // Packs fields MSB-first as {predictAddr, firstJPos, type, cutPosition}.
   function automatic logic [PAYLOAD_W-1:0] packPayload(
      input logic [ADDR_W-1:0] predictAddr,
      input logic [JPOS_W-1:0] firstJPos,
      input predType_e         brType,
      input logic [CUT_W-1:0]  cutPosition
   );
      return {predictAddr, firstJPos, brType, cutPosition};
   endfunction

endpackage

// File: rtl/pred_merge_queue_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, searching from the
// requester after the last winner; the pointer only moves on a real grant.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant,
   output logic         grantValid
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] winIdx;
   logic [PW:0]   cand;

   // Walk the requesters starting at ptr, wrapping at N; first hit wins.
   always_comb begin
      grant      = '0;
      grantValid = 1'b0;
      winIdx     = '0;
      cand       = '0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (!grantValid && req[cand[PW-1:0]]) begin
               grantValid           = 1'b1;
               winIdx               = cand[PW-1:0];
               grant[cand[PW-1:0]]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grantValid) begin
         ptr <= (winIdx == PW'(N-1)) ? '0 : winIdx + 1'b1;
      end
   end

endmodule

// File: rtl/pred_merge_queue.sv
// Merges one-shot predictor requests from N_CH channels into a small FIFO and
// hands entries one at a time to the instruction queue with a pulse handshake.
module pred_merge_queue
   import pred_merge_queue_pkg::*;
#(
   parameter int N_CH  = 3,
   parameter int WIDTH = 46,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         i_drive,
   input  logic [N_CH*WIDTH-1:0]   i_data,
   output logic [N_CH-1:0]         o_free,
   output logic                    o_driveNext,
   output logic [WIDTH-1:0]        o_data,
   input  logic                    i_freeNext,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  freeReg;
   logic             grantValid;
   logic [WIDTH-1:0] grantData;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [CW-1:0]    count;
   logic             overrun;
   logic             canAccept;
   logic             push;
   logic             pop;
   outState_e        state;
   outState_e        stateNext;

   // Admission uses the pre-pop occupancy, so a same-cycle pop never frees a slot early.
   assign canAccept = (count < CW'(DEPTH));
   assign push      = grantValid;
   assign pop       = (state == S_WAIT) && i_freeNext;

   rr_arbiter #(.N(N_CH)) arbiter (
      .clk        (clk),
      .rst        (rst),
      .req        (pending),
      .en         (canAccept),
      .grant      (grant),
      .grantValid (grantValid)
   );

   always_comb begin
      grantData = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (grant[k]) grantData = i_data[k*WIDTH +: WIDTH];
      end
   end

   // Announce the head once per entry, then hold until the queue consumes it.
   always_comb begin
      stateNext   = state;
      o_driveNext = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               o_driveNext = 1'b1;
               stateNext   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_freeNext) stateNext = S_IDLE;
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= stateNext;
   end

   // A repeat request on a still-pending channel is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         freeReg <= '0;
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= (pending & ~grant) | (i_drive & ~pending);
         freeReg <= grant;
         if (|(i_drive & pending)) overrun <= 1'b1;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wrPtr] <= grantData;
   end

   assign o_data    = (count != '0) ? mem[rdPtr] : '0;
   assign o_free    = freeReg;
   assign o_count   = count;
   assign o_overrun = overrun;

endmodule

// File: tb/tb_pred_merge_queue.sv
// Randomized and directed bench for pred_merge_queue, compared every cycle
// against a queue-based behavioural model of the merge/handshake rules.
module tb_pred_merge_queue;
   import pred_merge_queue_pkg::*;

   localparam int N  = 3;
   localparam int W  = 46;
   localparam int D  = 4;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   i_drive;
   logic [N*W-1:0] i_data;
   logic [N-1:0]   o_free;
   logic           o_driveNext;
   logic [W-1:0]   o_data;
   logic           i_freeNext;
   logic [CW-1:0]  o_count;
   logic           o_overrun;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycle       = 0;

   bit           mPending [N];
   logic [W-1:0] mQueue [$];
   int           mStart;
   bit           mWaiting;
   bit           mOverrun;
   logic [N-1:0] mFree;
   logic [W-1:0] chData [N];
   logic [W-1:0] savedA;

   always #5 clk = ~clk;

   pred_merge_queue #(.N_CH(N), .WIDTH(W), .DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_drive     (i_drive),
      .i_data      (i_data),
      .o_free      (o_free),
      .o_driveNext (o_driveNext),
      .o_data      (o_data),
      .i_freeNext  (i_freeNext),
      .o_count     (o_count),
      .o_overrun   (o_overrun)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycle, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < N; k++) mPending[k] = 1'b0;
      mQueue.delete();
      mStart   = 0;
      mWaiting = 1'b0;
      mOverrun = 1'b0;
      mFree    = '0;
   endtask

   // One clock cycle: drive inputs, compare outputs to the model, advance the model.
   task automatic applyStimulus(input logic [N-1:0] drive, input logic freeNext, input logic rstIn);
      bit           oldPend [N];
      bit           expDrive;
      logic [W-1:0] expData;
      int           winner;
      int           k;
      for (int c = 0; c < N; c++) begin
         if (drive[c] && !mPending[c])
            chData[c] = packPayload($urandom, 3'($urandom_range(0, 7)),
                                    predType_e'($urandom_range(0, 5)), 8'($urandom));
      end
      i_drive    = drive;
      i_freeNext = freeNext;
      rst        = rstIn;
      for (int c = 0; c < N; c++) i_data[c*W +: W] = chData[c];

      expDrive = !mWaiting && (mQueue.size() > 0);
      expData  = (mQueue.size() > 0) ? mQueue[0] : '0;
      checkOutput("o_free",      64'(o_free),      64'(mFree));
      checkOutput("o_driveNext", 64'(o_driveNext), 64'(expDrive));
      checkOutput("o_count",     64'(o_count),     64'(mQueue.size()));
      checkOutput("o_data",      64'(o_data),      64'(expData));
      checkOutput("o_overrun",   64'(o_overrun),   64'(mOverrun));

      if (rstIn) begin
         modelReset();
      end else begin
         winner = -1;
         if (mQueue.size() < D) begin
            for (int i = 0; i < N; i++) begin
               k = (mStart + i) % N;
               if (winner < 0 && mPending[k]) winner = k;
            end
         end
         for (int c = 0; c < N; c++) oldPend[c] = mPending[c];
         if (mWaiting && freeNext) begin
            void'(mQueue.pop_front());
            mWaiting = 1'b0;
         end else if (expDrive) begin
            mWaiting = 1'b1;
         end
         mFree = '0;
         if (winner >= 0) begin
            mQueue.push_back(chData[winner]);
            mPending[winner] = 1'b0;
            mFree[winner]    = 1'b1;
            mStart           = (winner + 1) % N;
         end
         for (int c = 0; c < N; c++) begin
            if (drive[c] && oldPend[c]) mOverrun = 1'b1;
            if (drive[c] && !oldPend[c]) mPending[c] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic runCycles(input int n, input bit respond);
      for (int i = 0; i < n; i++) applyStimulus('0, respond && mWaiting, 1'b0);
   endtask

   task automatic resetDut();
      applyStimulus('0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [N-1:0] d;
      logic         fn;
      logic         r;
      rst        = 1'b1;
      i_drive    = '0;
      i_freeNext = 1'b0;
      i_data     = '0;
      for (int c = 0; c < N; c++) chData[c] = '0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();

      // Single request: o_free and the head announcement two cycles later.
      resetDut();
      applyStimulus(3'b001, 1'b0, 1'b0);
      savedA = chData[0];
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("single_free",      64'(o_free),      64'(3'b001));
      checkOutput("single_driveNext", 64'(o_driveNext), 64'(1'b1));
      checkOutput("single_data",      64'(o_data),      64'(savedA));
      runCycles(4, 1'b1);

      // Simultaneous requests, twice, with a reset between: order restarts at ch0.
      for (int rep = 0; rep < 2; rep++) begin
         resetDut();
         applyStimulus(3'b111, 1'b0, 1'b0);
         applyStimulus('0, 1'b0, 1'b0);
         checkOutput("rr_first",  64'(o_free), 64'(3'b001));
         applyStimulus('0, 1'b0, 1'b0);
         checkOutput("rr_second", 64'(o_free), 64'(3'b010));
         applyStimulus('0, 1'b0, 1'b0);
         checkOutput("rr_third",  64'(o_free), 64'(3'b100));
         runCycles(12, 1'b1);
      end

      // Full buffer with a held fifth request, then a duplicate on that channel.
      resetDut();
      applyStimulus(3'b111, 1'b0, 1'b0);
      applyStimulus('0,     1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      runCycles(4, 1'b0);
      checkOutput("full_count", 64'(o_count), 64'(4));
      checkOutput("full_held",  64'(o_free),  64'(0));
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus('0,     1'b0, 1'b0);
      checkOutput("overrun_flag",  64'(o_overrun), 64'(1'b1));
      checkOutput("overrun_count", 64'(o_count),   64'(4));
      applyStimulus('0, 1'b1, 1'b0);
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("full_release", 64'(o_free), 64'(3'b010));
      runCycles(30, 1'b1);
      checkOutput("drain_count",  64'(o_count),   64'(0));
      checkOutput("drain_sticky", 64'(o_overrun), 64'(1'b1));

      // Ten sequential entries through the four-entry buffer.
      resetDut();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(N'(1 << (i % N)), 1'b0, 1'b0);
         runCycles(5, 1'b1);
      end
      checkOutput("wrap_count", 64'(o_count), 64'(0));

      // Reset with three buffered entries and one pending request.
      resetDut();
      applyStimulus(3'b111, 1'b0, 1'b0);
      applyStimulus('0,     1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus('0,     1'b0, 1'b0);
      checkOutput("midrst_pre_count", 64'(o_count), 64'(3));
      resetDut();
      for (int i = 0; i < 5; i++) begin
         checkOutput("midrst_count", 64'(o_count),     64'(0));
         checkOutput("midrst_free",  64'(o_free),      64'(0));
         checkOutput("midrst_drive", 64'(o_driveNext), 64'(0));
         applyStimulus('0, 1'b0, 1'b0);
      end

      // Random traffic, including spurious i_freeNext and occasional reset.
      resetDut();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) d[k] = ($urandom_range(0, 3) == 0);
         fn = mWaiting ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         r  = ($urandom_range(0, 499) == 0);
         applyStimulus(d, fn, r);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
